// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and address constants for the MMIO bridge.
// Holds the CPU command encoding, the bridge FSM states and the I/O addresses.
package mmio_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        ACK     = 2'b10,
        DRAIN   = 2'b11
    } bridge_state_t;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

endpackage

// File: rtl/sw_sync_debounce.sv
// sw_sync_debounce: two-flop synchronizer for asynchronous switches, with
// optional per-bit debounce when MMIO_SW_DEBOUNCE_EN is defined.
// Ports: i_clk, i_rst_n (async active-low), i_sw [W] raw, o_sw_val [W] clean.
module sw_sync_debounce #(
    parameter int W               = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_sw,
    output logic [W-1:0] o_sw_val
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef MMIO_SW_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < W; i++) begin : g_db
        logic [CW-1:0] r_cnt;
        logic          r_bit;

        // Counter runs only while the synchronized bit disagrees with the
        // accepted value; any agreement (bounce back) restarts it.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (r_sync2[i] == r_bit) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt <= '0;
                r_bit <= r_sync2[i];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign o_sw_val[i] = r_bit;
    end
`else
    assign o_sw_val = r_sync2;
`endif

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes CPU memory commands to RAM, LED register or switches,
// completing each transfer with a one-cycle mem_ready pulse.
// Ports: clk, reset_n, mem_cmd/mem_addr/write_data -> read_data/mem_ready;
// ram_addr/ram_write/ram_din/ram_dout to RAM; sw_in, ledr, addr_err.
// Optional switch debounce: define MMIO_SW_DEBOUNCE_EN.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic [7:0]  ram_addr,
    output logic        ram_write,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  sw_in,
    output logic [7:0]  ledr,
    output logic        addr_err
);

    bridge_state_t r_state;
    logic [15:0]   r_read_data;
    logic          r_mem_ready;
    logic [7:0]    r_ledr;
    logic          r_addr_err;

    logic       w_rd;
    logic       w_wr;
    logic       w_is_ram;
    logic       w_is_led;
    logic       w_is_sw;
    logic [7:0] w_sw_val;

    sw_sync_debounce #(
        .W               (8),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw (
        .i_clk    (clk),
        .i_rst_n  (reset_n),
        .i_sw     (sw_in),
        .o_sw_val (w_sw_val)
    );

    assign w_rd     = (mem_cmd == MREAD);
    assign w_wr     = (mem_cmd == MWRITE);
    assign w_is_ram = ~mem_addr[8];
    assign w_is_led = (mem_addr == LED_ADDR);
    assign w_is_sw  = (mem_addr == SW_ADDR);

    // Gated by reset_n so an aborted write drops immediately.
    assign ram_write = reset_n && (r_state == IDLE) && w_wr && w_is_ram;
    assign ram_addr  = mem_addr[7:0];
    assign ram_din   = write_data;

    assign read_data = r_read_data;
    assign mem_ready = r_mem_ready;
    assign ledr      = r_ledr;
    assign addr_err  = r_addr_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_read_data <= '0;
            r_mem_ready <= 1'b0;
            r_ledr      <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            r_mem_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rd || w_wr) begin
                        if (w_is_ram) begin
                            r_state     <= w_wr ? ACK : RD_WAIT;
                            r_mem_ready <= w_wr;
                        end else begin
                            r_state     <= ACK;
                            r_mem_ready <= 1'b1;
                            if (w_is_led) begin
                                if (w_wr) r_ledr <= write_data[7:0];
                                else      r_read_data <= {8'b0, r_ledr};
                            end else if (w_is_sw) begin
                                if (w_rd) r_read_data <= {8'b0, w_sw_val};
                            end else begin
                                r_addr_err <= 1'b1;
                                if (w_rd) r_read_data <= '0;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    r_read_data <= ram_dout;
                    r_mem_ready <= 1'b1;
                    r_state     <= ACK;
                end
                ACK: begin
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    // Wait for the CPU to withdraw so a held command runs once.
                    if (!w_rd && !w_wr) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Memory-side bridge sitting directly downstream of the CPU's memory port. It decodes each CPU memory command by address and routes it to one of three targets: the 256-word instruction/data RAM, a memory-mapped LED output register, or a memory-mapped switch input. It completes every transfer with a one-cycle `mem_ready` handshake, and resynchronizes the asynchronous switch inputs into the clock domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a switch change is accepted. Used only when debounce is compiled in.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_cmd`  in  2  CPU command: MNONE=00, MREAD=01, MWRITE=10; 11 treated as MNONE.
- `mem_addr`  in  9  CPU word address.
- `write_data`  in  16  CPU store data.
- `read_data`  out  16  load data; valid while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle transfer-complete pulse.
- `ram_addr`  out  8  RAM word address; equals `mem_addr[7:0]`.
- `ram_write`  out  1  RAM write enable.
- `ram_din`  out  16  RAM write data; equals `write_data`.
- `ram_dout`  in  16  RAM synchronous read data; valid one cycle after the address is presented.
- `sw_in`  in  8  raw asynchronous switches.
- `ledr`  out  8  LED register.
- `addr_err`  out  1  sticky flag for any access to an unmapped address.

## Operation
Address map:
- `mem_addr[8]`=0: RAM.
- 0x100: LED register. Writes load `write_data[7:0]`; reads return `{8'b0, ledr}`.
- 0x140: switches. Reads return `{8'b0, sw_val}`; writes are ignored but still acknowledged.
- Any other address: reads return 0, writes are dropped, and `addr_err` is set. The transfer is still acknowledged.

The FSM has four states: IDLE, RD_WAIT, ACK, DRAIN.
- IDLE, MWRITE to RAM: `ram_write`=1 combinationally during this cycle → ACK.
- IDLE, MREAD to RAM: `ram_addr` is presented → RD_WAIT.
- IDLE, MWRITE or MREAD to I/O or unmapped: the register update and `read_data` capture happen at the clock edge → ACK.
- RD_WAIT: `read_data` ← `ram_dout` at the edge → ACK.
- ACK: `mem_ready`=1 for exactly this cycle → DRAIN.
- DRAIN: stay until `mem_cmd`=MNONE, then → IDLE. A held command is never executed twice.
- `ram_write` is asserted only in IDLE on a decoded RAM write, so it is never high for more than one cycle per transfer.
- `read_data` holds its last value outside ACK. After a write it is not updated.
- The CPU must hold `mem_cmd`, `mem_addr` and `write_data` stable from issue until it sees `mem_ready`.

## Timing
Latency is measured from the edge at which the command is sampled in IDLE:
- RAM write: `mem_ready` appears 1 cycle later; RAM contents are updated at the sampling edge.
- RAM read: `mem_ready` and data appear 2 cycles later.
- I/O or unmapped access: 1 cycle.
- Minimum spacing between back-to-back transfers is 3 cycles for writes and 4 for reads, because DRAIN plus IDLE each take at least one cycle.

Reset values (applied immediately and asynchronously on `reset_n`=0):
- State = IDLE
- `read_data` = 0, `mem_ready` = 0, `ram_write` = 0
- `ledr` = 0, `addr_err` = 0
- synchronizer flops and `sw_val` = 0

Reset in mid-transfer:
- The transfer is aborted and `ram_write` drops at once.
- A read in RD_WAIT produces no `mem_ready`.
- After release the bridge is in IDLE. If a command is still held at that point, it executes once.

Switch path:
- Two-flop synchronizer, so switch reads reflect `sw_in` at least 2 cycles old.
- LED write followed immediately by an LED read: the read returns the new value.

## Configuration
- `MMIO_SW_DEBOUNCE_EN` defined: each synchronized switch bit has its own counter.
  - A bit's `sw_val` takes a new value only after the synchronized bit differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce back resets that bit's counter.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Not defined: `sw_val` is the synchronizer output directly, and no counters exist.

## Structure
- Package `mmio_pkg` holds:
  - the `mem_cmd_t` enum (MNONE, MREAD, MWRITE);
  - constants `LED_ADDR`=9'h100 and `SW_ADDR`=9'h140;
  - the `bridge_state_t` enum.
- Sub-module `sw_sync_debounce` contains the synchronizer and the optional debounce logic, is parameterized by width and `DEBOUNCE_CYCLES`, and outputs `sw_val`.
- Decode and FSM stay in `mmio_bridge`.

## Test plan
- Reset with `reset_n`=0 while MREAD 0x005 is held → all outputs 0. After release: `mem_ready` at cycle 2, `read_data`=RAM[5] (load 16'h4321 → 16'h4321).
- MWRITE 0x007, data 16'hFAFA → `ram_write` high for exactly 1 cycle with `ram_addr`=7. Then `mem_ready`. A following MREAD 0x007 returns 16'hFAFA.
- MWRITE 0x100 with 16'h12A5 → `ledr`=8'hA5 after 1 cycle. MREAD 0x100 → 16'h00A5.
- Set `sw_in`=8'h3C and wait 3 cycles, then MREAD 0x140 → 16'h003C. With debounce on and `DEBOUNCE_CYCLES`=4, a 2-cycle glitch to 8'hFF is not visible.
- MREAD 0x1FF → `read_data`=0, `mem_ready` after 1 cycle, `addr_err`=1 and remains 1 until reset.
- Hold MWRITE 0x003 for 6 cycles → exactly one `ram_write` pulse and one `mem_ready`. The bridge stays in DRAIN until MNONE.
